// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding imem request at a time,
// and queues returned instructions for decode. Handles redirect/flush, stale-response drop and HALT.
module fetch_prefetch_queue #(
    parameter int               ADDR_W   = 16,
    parameter int               INSTR_W  = 16,
    parameter int               DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int               PC_INC   = 2,
    parameter logic [4:0]       HALT_OP  = 5'b00000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rdy,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_pc_next,
    input  logic               out_ready,
    output logic               halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DROP, ST_HALTED} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   fetch_pc_reg, fetch_pc_next;
    logic [ADDR_W-1:0]   req_pc_reg, req_pc_next;
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;

    logic [INSTR_W-1:0]  fifo_instr [DEPTH];
    logic [ADDR_W-1:0]   fifo_pc    [DEPTH];

    logic accept, push, pop, is_halt;

    assign is_halt = (imem_rdata[INSTR_W-1 -: 5] == HALT_OP);

    // Space is reserved at issue, so a later push can never overflow the queue.
    assign imem_req  = !rst && (state_reg == ST_IDLE) && (count_reg < CNT_W'(DEPTH)) && !redirect_valid;
    assign imem_addr = fetch_pc_reg;
    assign accept    = imem_req && imem_rdy;
    assign push      = (state_reg == ST_WAIT) && imem_rvalid && !redirect_valid;
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign halted    = (state_reg == ST_HALTED);

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        req_pc_next   = req_pc_reg;
        if (redirect_valid) begin
            fetch_pc_next = redirect_pc;
            // An outstanding request must still be drained unless its response lands right now.
            case (state_reg)
                ST_WAIT, ST_DROP: state_next = imem_rvalid ? ST_IDLE : ST_DROP;
                default:          state_next = ST_IDLE;
            endcase
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        fetch_pc_next = fetch_pc_reg + ADDR_W'(PC_INC);
                        req_pc_next   = fetch_pc_reg;
                        state_next    = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) state_next = is_halt ? ST_HALTED : ST_IDLE;
                end
                ST_DROP: begin
                    if (imem_rvalid) state_next = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            fetch_pc_reg <= RESET_PC;
            req_pc_reg   <= RESET_PC;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            req_pc_reg   <= req_pc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (redirect_valid) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage carries no reset; the head is masked to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr_reg] <= imem_rdata;
            fifo_pc[wr_ptr_reg]    <= req_pc_reg;
        end
    end

    assign out_valid   = (count_reg != '0);
    assign out_instr   = out_valid ? fifo_instr[rd_ptr_reg] : '0;
    assign out_pc      = out_valid ? fifo_pc[rd_ptr_reg] : '0;
    assign out_pc_next = out_pc + ADDR_W'(PC_INC);

endmodule
